// File: rtl/mont_exp_param_if.sv
// Request/response bundle for the parametrised Montgomery exponentiator.
// master drives operands and start; slave (the exponentiator) returns result/done/busy.
interface mont_exp_param_if #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     msg;
  logic [EXP_WIDTH-1:0] exp;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     rmodn;
  logic [WIDTH-1:0]     r2modn;
  logic [WIDTH-1:0]     result;
  logic                 done;
  logic                 busy;

  modport master (
    output start, msg, exp, n, rmodn, r2modn,
    input  result, done, busy
  );

  modport slave (
    input  start, msg, exp, n, rmodn, r2modn,
    output result, done, busy
  );
endinterface

// File: rtl/mont_exp_param.sv
// Montgomery modular exponentiator: result = msg^exp mod n, one bit-serial radix-2 MontMul.
// Default build: left-to-right square-and-multiply with leading-zero skip.
// Define MONT_EXP_CT_EN for a constant-time Montgomery ladder (fixed 2*EXP_WIDTH+2 calls).
module mont_exp_param #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 16
) (
  input logic            clk,
  input logic            resetn,
  mont_exp_param_if.slave bus
);
  localparam int unsigned TW   = WIDTH + 2;
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam int unsigned IdxW = $clog2(EXP_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH + 1);

`ifdef MONT_EXP_CT_EN
  typedef enum logic [2:0] {
    StIdle, StLoad, StToMont, StLadderA, StLadderB, StFromMont, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLoad, StToMont, StSquare, StMult, StFromMont, StDone
  } state_e;
`endif

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [TW-1:0]        t_q;
  logic [WIDTH-1:0]     a_q, b_q;
  // acc_q holds A (or R0 on the ladder); x_q holds X (or R1)
  logic [WIDTH-1:0]     acc_q, x_q;
  logic [WIDTH-1:0]     msg_q, n_q, rmodn_q, r2modn_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     result_q;
  logic                 done_q, busy_q;

  logic [WIDTH-1:0] op_a, op_b, prod;
  logic [TW-1:0]    n_ext, sum_add, sum_red;
  logic             cur_bit, mult_active, mult_last;

  assign cur_bit   = exp_q[idx_q];
  assign mult_last = (cnt_q == LastCnt);
  assign n_ext     = {2'b00, n_q};

`ifdef MONT_EXP_CT_EN
  assign mult_active = state_q inside {StToMont, StLadderA, StLadderB, StFromMont};
`else
  assign mult_active = state_q inside {StToMont, StSquare, StMult, StFromMont};

  logic [IdxW-1:0] msb_idx;
  // Index of the highest set exponent bit, used to skip leading zeros
  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) msb_idx = IdxW'(i);
    end
  end
`endif

  // Operand selection for the multiplier call owned by the current state
  always_comb begin
    op_a = acc_q;
    op_b = acc_q;
    case (state_q)
      StToMont: begin
        op_a = msg_q;
        op_b = r2modn_q;
      end
      StFromMont: op_b = WIDTH'(1);
`ifdef MONT_EXP_CT_EN
      StLadderA: op_b = x_q;
      StLadderB: begin
        // square whichever register the first product did not overwrite
        op_a = cur_bit ? x_q : acc_q;
        op_b = cur_bit ? x_q : acc_q;
      end
`else
      StMult: op_b = x_q;
`endif
      default: ;
    endcase
  end

  // One radix-2 Montgomery iteration and the final conditional subtract
  always_comb begin
    sum_add = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    sum_red = sum_add + (sum_add[0] ? n_ext : '0);
    prod    = (t_q >= n_ext) ? WIDTH'(t_q - n_ext) : t_q[WIDTH-1:0];
  end

  // Sequencing FSM, multiplier datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      msg_q    <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      rmodn_q  <= '0;
      r2modn_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Each call: 1 load cycle, WIDTH iterations, 1 subtract/writeback cycle
      if (mult_active) begin
        if (cnt_q == '0) begin
          t_q   <= '0;
          a_q   <= op_a;
          b_q   <= op_b;
          cnt_q <= cnt_q + CntW'(1);
        end else if (!mult_last) begin
          t_q   <= sum_red >> 1;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CntW'(1);
        end else begin
          cnt_q <= '0;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            msg_q    <= bus.msg;
            exp_q    <= bus.exp;
            n_q      <= bus.n;
            rmodn_q  <= bus.rmodn;
            r2modn_q <= bus.r2modn;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          acc_q <= rmodn_q;
`ifdef MONT_EXP_CT_EN
          idx_q   <= IdxW'(EXP_WIDTH - 1);
          state_q <= StToMont;
`else
          idx_q   <= msb_idx;
          state_q <= (exp_q == '0) ? StFromMont : StToMont;
`endif
        end
        StToMont: begin
          if (mult_last) begin
            x_q <= prod;
`ifdef MONT_EXP_CT_EN
            state_q <= StLadderA;
`else
            acc_q <= prod;
            if (idx_q == '0) begin
              state_q <= StFromMont;
            end else begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StSquare;
            end
`endif
          end
        end
`ifdef MONT_EXP_CT_EN
        StLadderA: begin
          if (mult_last) begin
            if (cur_bit) acc_q <= prod;
            else         x_q   <= prod;
            state_q <= StLadderB;
          end
        end
        StLadderB: begin
          if (mult_last) begin
            if (cur_bit) x_q   <= prod;
            else         acc_q <= prod;
            if (idx_q == '0) begin
              state_q <= StFromMont;
            end else begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StLadderA;
            end
          end
        end
`else
        StSquare: begin
          if (mult_last) begin
            acc_q <= prod;
            if (cur_bit) begin
              state_q <= StMult;
            end else if (idx_q == '0) begin
              state_q <= StFromMont;
            end else begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StSquare;
            end
          end
        end
        StMult: begin
          if (mult_last) begin
            acc_q <= prod;
            if (idx_q == '0) begin
              state_q <= StFromMont;
            end else begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StSquare;
            end
          end
        end
`endif
        StFromMont: begin
          if (mult_last) begin
            acc_q   <= prod;
            state_q <= StDone;
          end
        end
        StDone: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_mont_exp_param.sv
// Randomised scoreboard bench for mont_exp_param at WIDTH=8, EXP_WIDTH=16.
// Expected results come from plain modular arithmetic; expected done latency from the call count.
module tb_mont_exp_param;
  localparam int unsigned W  = 8;
  localparam int unsigned EW = 16;
  localparam int unsigned M  = W + 2;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  exp_t        sb[$];

  mont_exp_param_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  mont_exp_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [W-1:0] ref_pow(input longint unsigned m, input logic [EW-1:0] e,
                                           input longint unsigned nn);
    longint unsigned r, b;
    r = 1;
    b = m % nn;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return W'(r % nn);
  endfunction

  function automatic int unsigned lat(input logic [EW-1:0] e);
    int unsigned calls;
`ifdef MONT_EXP_CT_EN
    calls = 2 * EW + 2;
`else
    int unsigned ones;
    int          hi;
    ones = 0;
    hi   = -1;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        hi = i;
        ones++;
      end
    end
    calls = (hi < 0) ? 1 : int'(hi) + ones + 1;
`endif
    return calls * M + 2;
  endfunction

  task automatic drive(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] nn);
    longint unsigned one = 1;
    bus.msg    = m;
    bus.exp    = e;
    bus.n      = nn;
    bus.rmodn  = W'((one << W) % longint'(nn));
    bus.r2modn = W'((one << (2 * W)) % longint'(nn));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_bound", 64'(k < 1000), 64'd1);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] nn,
                       input bit hold);
    wait_idle();
    drive(m, e, nn);
    bus.start = 1'b1;
    @(negedge clk);
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    sb.push_back('{res: ref_pow(m, e, nn), due: cyc + lat(e)});
    if (!hold) bus.start = 1'b0;
  endtask

  // Monitor: pop the oldest expectation whenever done is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("done_latency", 64'(cyc), 64'(e.due));
          check("busy_low_at_done", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [W-1:0]  nn, m;
    logic [EW-1:0] e;
    int            k;
    bus.start = 1'b0;
    drive(8'h00, 16'h0001, 8'hC5);
    repeat (3) @(negedge clk);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue(8'h05, 16'h0003, 8'hC5, 1'b0);
    issue(8'h02, 16'h000A, 8'hC5, 1'b0);
    issue(8'h02, 16'h0000, 8'hC5, 1'b0);

    // Randomised back-to-back runs
    for (int i = 0; i < 20; i++) begin
      nn = W'(2 * $urandom_range(1, 127) + 1);
      m  = W'($urandom % nn);
      case ($urandom % 4)
        0:       e = '0;
        1:       e = EW'($urandom_range(1, 15));
        default: e = EW'($urandom);
      endcase
      issue(m, e, nn, 1'b0);
    end

    // Start while busy is ignored; operands changing after acceptance are harmless
    issue(8'h07, 16'hF0F1, 8'hB3, 1'b0);
    repeat (7) @(negedge clk);
    drive(8'h11, 16'h0001, 8'h25);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_through_ignored_start", 64'(bus.busy), 64'd1);

    // Start held high through the done cycle launches the next run
    issue(8'h09, 16'h0105, 8'hE7, 1'b1);
    drive(8'h2A, 16'h8003, 8'h9B);
    wait_idle();
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_reasserts_after_done", 64'(bus.busy), 64'd1);
    sb.push_back('{res: ref_pow(8'h2A, 16'h8003, 8'h9B), due: cyc + lat(16'h8003)});

    // Reset mid-run aborts without a done pulse
    issue(8'h03, 16'h00FF, 8'hF1, 1'b0);
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    issue(8'h03, 16'h00FF, 8'hF1, 1'b0);

    k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mont_exp_param.md
# mont_exp_param

Parametrised Montgomery modular exponentiator computing result = msg^exp mod n for an odd modulus of WIDTH bits and an exponent of EXP_WIDTH bits. It is the next-generation replacement for the fixed 1024-bit / 16-bit exponentiator in the RSA datapath. It contains a single bit-serial radix-2 Montgomery multiplier, a sequencing FSM and a busy/done handshake. A compile-time option selects a constant-time Montgomery ladder.

## Interface
- WIDTH, 1024, modulus/operand width in bits (≥ 8)
- EXP_WIDTH, 16, exponent width in bits (≥ 2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; accepted only while busy == 0
- msg  in  WIDTH  base; must be < n
- exp  in  EXP_WIDTH  exponent
- n  in  WIDTH  modulus; must be odd, > 1
- rmodn  in  WIDTH  2^WIDTH mod n
- r2modn  in  WIDTH  2^(2·WIDTH) mod n
- result  out  WIDTH  msg^exp mod n; held until next accepted start
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high from the cycle after acceptance through the cycle before done

## Operation
- MontMul(a,b) = a·b·2^-WIDTH mod n.
  - Accumulator t is WIDTH+2 bits, cleared on load.
  - Per iteration i = 0..WIDTH-1: t += a[i]·b; if t odd, t += n; t >>= 1.
  - Final step: if t ≥ n, t -= n.
  - Every call occupies exactly M = WIDTH+2 cycles: 1 load, WIDTH iterations, 1 subtract.
- On acceptance, msg, exp, n, rmodn and r2modn are latched. Inputs may change afterwards.
- Default algorithm (left-to-right square-and-multiply with leading-zero skip):
  - exp == 0: A = rmodn, then go directly to FROMMONT. Multiplier calls = 1.
  - Otherwise, let p be the index of the highest set bit of exp.
    - X = MontMul(msg, r2modn); A = X.
    - For i = p-1 down to 0: A = MontMul(A,A); if exp[i] == 1, A = MontMul(A,X).
    - Then result = MontMul(A,1).
    - Multiplier calls = p + popcount(exp) + 1.
- FSM states: IDLE → LOAD → TOMONT → SQUARE ⇄ MULT → FROMMONT → DONE → IDLE.
  - LOAD goes straight to FROMMONT when exp == 0.
  - SQUARE → MULT when the current bit is 1; otherwise it decrements the bit index or exits to FROMMONT.
- No reduction or validity check is done on the inputs. If msg ≥ n, n is even, or rmodn/r2modn are wrong, result is unspecified, but done still pulses at the normal latency.

## Timing
- Reset values: result = 0, done = 0, busy = 0, FSM = IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse is issued.
- Start is sampled at edge 0. busy is high from edge 1.
- done pulses at edge L = calls·M + 2 (1 LOAD cycle + 1 DONE register cycle).
- result updates on the same edge as done. busy falls on that edge.
- Start while busy == 1 is ignored and not queued.
- Start asserted during the done cycle is accepted (busy is already 0).
- result is unchanged from done until the next done.

## Configuration
- MONT_EXP_CT_EN defined: constant-time Montgomery ladder.
  - R0 = rmodn, R1 = MontMul(msg, r2modn).
  - For i = EXP_WIDTH-1 down to 0, with both products using pre-update operands:
    - bit = 1: R0 = R0·R1, then R1 = R1·R1.
    - bit = 0: R1 = R0·R1, then R0 = R0·R0.
  - result = MontMul(R0,1).
  - Calls are always 2·EXP_WIDTH + 2, independent of exp (including exp == 0). There is no leading-zero skip.
  - FSM states: IDLE → LOAD → TOMONT → LADDER_A → LADDER_B → FROMMONT → DONE.
- MONT_EXP_CT_EN undefined: default algorithm above; latency depends on the data.

## Test plan
- WIDTH = 8, EXP_WIDTH = 16, n = 0xC5, rmodn = 0x3B, r2modn = 0x84, msg = 0x05, exp = 0x0003 → result 0x7D, done at L = 4·10+2 = 42 (CT: 34·10+2 = 342).
- Same n, msg = 0x02, exp = 0x000A → result 0x27, L = 62 (CT: 342).
- Same n, msg = 0x02, exp = 0x0000 → result 0x01, L = 12 (CT: 342).
- WIDTH = 1024 golden vector with exp = 0xB5DF → result matches the software model bit-exactly, L = 28·1026+2 = 28730 (CT: 34·1026+2 = 34886).
- Start pulsed again mid-run → ignored, first result unchanged. Start held high through the done cycle → second run accepted, busy re-asserts on the next edge.
- resetn pulsed low mid-run → result = 0, busy = 0, no done. A fresh start then yields a correct result.
